// File: rtl/core_mem_arbiter.sv
// Single-port memory arbiter between RV32I instruction fetch (IF) and load/store (LS).
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module core_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RSP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            state;
    logic              owner_ls;
    logic [7:0]        starve_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic              take_ls;
    logic              cur_ls;
    logic              issue;
    logic              grant;
    logic              rsp;
    logic              timeout_hit;
    logic [DATA_W-1:0] rsp_data;

    // Every combinational output is qualified by rst so reset silences the port at once.
    always_comb begin
        take_ls  = ls_req && (!if_req || starve_cnt != LIMIT);
        cur_ls   = (state == IDLE) ? take_ls : owner_ls;
        issue    = rst && (((state == IDLE) && (if_req || ls_req)) || (state == WAIT_ACC));
        grant    = issue && mem_ready;
        rsp      = rst && (state == WAIT_RSP) && (mem_rvalid || timeout_hit);
        rsp_data = mem_rvalid ? mem_rdata : '0;
    end

    assign mem_req   = issue;
    assign mem_we    = issue && cur_ls && ls_we;
    assign mem_addr  = !issue ? '0 : (cur_ls ? ls_addr : if_addr);
    assign mem_wdata = (issue && cur_ls) ? ls_wdata : '0;
    assign mem_wmask = (issue && cur_ls) ? ls_wmask : '0;

    assign if_gnt    = grant && !cur_ls;
    assign ls_gnt    = grant && cur_ls;
    assign if_rvalid = rsp && !owner_ls;
    assign ls_rvalid = rsp && owner_ls;
    assign if_rdata  = !rst ? '0 : (if_rvalid ? rsp_data : if_rdata_q);
    assign ls_rdata  = !rst ? '0 : (ls_rvalid ? rsp_data : ls_rdata_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_rvalid) if_rdata_q <= rsp_data;
            if (ls_rvalid) ls_rdata_q <= rsp_data;

            // Starvation guard only counts LS wins that actually kept IF waiting.
            if (grant) begin
                if (!cur_ls)
                    starve_cnt <= '0;
                else if (if_req && starve_cnt < LIMIT)
                    starve_cnt <= starve_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (issue) begin
                        owner_ls <= take_ls;
                        state    <= mem_ready ? WAIT_RSP : WAIT_ACC;
                    end
                end
                WAIT_ACC: begin
                    if (mem_ready) state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (rsp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          to_err;

    // Counter sits at zero outside WAIT_RSP, so it is cleared on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (state != WAIT_RSP)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYC))
                to_cnt <= to_cnt + 1'b1;
            if (timeout_hit && !mem_rvalid && state == WAIT_RSP)
                to_err <= 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT_RSP) && (to_cnt == TW'(TIMEOUT_CYC));
    assign timeout_err = to_err;
`else
    // Watchdog compiled out; the comparison is constant false and keeps the parameter referenced.
    assign timeout_hit = (TIMEOUT_CYC < 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_core_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;
    localparam int TO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req, ls_req, ls_we, mem_ready, mem_rvalid;
    logic [ADDR_W-1:0] if_addr, ls_addr, mem_addr;
    logic [DATA_W-1:0] ls_wdata, mem_rdata, if_rdata, ls_rdata, mem_wdata;
    logic [3:0]        ls_wmask, mem_wmask;
    logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    core_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        if_req = 1; ls_req = 1; ls_we = 1; ls_addr = '1; ls_wdata = '1; ls_wmask = '1;
        mem_ready = 1; mem_rvalid = 1; mem_rdata = '1;
        rst = 0; #2;
        vectors++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            miscompares++; $display("FAIL reset_mem: got req=%0b addr=%h want all 0", mem_req, mem_addr);
        end
        vectors++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_hs: got %b want 0000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        vectors++;
        if ({if_rdata, ls_rdata, timeout_err} !== '0) begin
            miscompares++; $display("FAIL reset_data: got if=%h ls=%h err=%0b want 0", if_rdata, ls_rdata, timeout_err);
        end
        @(posedge clk); #1;
        idle_inputs(); rst = 1; #2;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle_req: got %0b want 0", mem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_if_fetch();
        apply_reset();
        if_req = 1; if_addr = 32'h0000_0010; mem_ready = 1; #2;
        vectors++;
        if ({if_gnt, ls_gnt, mem_req, mem_we} !== 4'b1010) begin
            miscompares++; $display("FAIL fetch_gnt: got gnt/lsgnt/req/we=%b want 1010", {if_gnt, ls_gnt, mem_req, mem_we});
        end
        vectors++;
        if (mem_addr !== 32'h0000_0010) begin
            miscompares++; $display("FAIL fetch_addr: got %h want 00000010", mem_addr);
        end
        @(posedge clk); #1;
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093; #2;
        vectors++;
        if ({if_rvalid, ls_rvalid, mem_req} !== 3'b100 || if_rdata !== 32'h0050_0093) begin
            miscompares++; $display("FAIL fetch_rsp: got rv=%b data=%h want 100 00500093", {if_rvalid, ls_rvalid, mem_req}, if_rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 0; mem_rdata = 32'h1234_5678; #2;
        vectors++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0050_0093 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL fetch_hold: got rv=%0b data=%h req=%0b want 0 00500093 0", if_rvalid, if_rdata, mem_req);
        end
        if_req = 1; if_addr = 32'h14; mem_ready = 1; #1;
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++; $display("FAIL fetch_back_idle: got if_gnt=%0b want 1", if_gnt);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_ls;
        apply_reset();
        if_req = 1; ls_req = 1; ls_we = 0; if_addr = 32'h200; ls_addr = 32'h300; mem_ready = 1;
        for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
            mem_rvalid = 0; #2;
            exp_ls = (g % (LIMIT + 1)) != LIMIT;
            vectors++;
            if (ls_gnt !== exp_ls || if_gnt !== !exp_ls) begin
                miscompares++; $display("FAIL starve_order g=%0d: got ls=%0b if=%0b want ls=%0b", g, ls_gnt, if_gnt, exp_ls);
            end
            vectors++;
            if (mem_addr !== (exp_ls ? 32'h300 : 32'h200)) begin
                miscompares++; $display("FAIL starve_addr g=%0d: got %h", g, mem_addr);
            end
            @(posedge clk); #1;
            mem_rvalid = 1; mem_rdata = 32'(g + 100); #2;
            vectors++;
            if (ls_rvalid !== exp_ls || if_rvalid !== !exp_ls) begin
                miscompares++; $display("FAIL starve_rsp g=%0d: got ls_rv=%0b if_rv=%0b want ls_rv=%0b", g, ls_rvalid, if_rvalid, exp_ls);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_store_wait_acc();
        apply_reset();
        ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 0;
            if (c == 1) begin if_req = 1; if_addr = 32'h44; end
            #2;
            vectors++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}
                || ls_gnt !== 1'b0 || if_gnt !== 1'b0) begin
                miscompares++; $display("FAIL store_wait c=%0d: got req=%0b we=%0b addr=%h wd=%h m=%b lg=%0b ig=%0b",
                                        c, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ls_gnt, if_gnt);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1; #2;
        vectors++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h100) begin
            miscompares++; $display("FAIL store_gnt: got ls=%0b if=%0b addr=%h want 1 0 100", ls_gnt, if_gnt, mem_addr);
        end
        @(posedge clk); #1;
        ls_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0; #2;
        vectors++;
        if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL store_ack: got ls_rv=%0b if_rv=%0b req=%0b want 1 0 0", ls_rvalid, if_rvalid, mem_req);
        end
        @(posedge clk); #1;
        mem_rvalid = 0; mem_ready = 1; #2;
        vectors++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h44) begin
            miscompares++; $display("FAIL store_then_if: got if_gnt=%0b addr=%h want 1 44", if_gnt, mem_addr);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        if_req = 1; if_addr = 32'h40; mem_ready = 1; #2;
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++; $display("FAIL rmid_gnt: got %0b want 1", if_gnt);
        end
        @(posedge clk); #1;
        if_req = 1; mem_ready = 1; #1;
        rst = 0; #1;
        vectors++;
        if ({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b00000) begin
            miscompares++; $display("FAIL rmid_async: got %b want 00000", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        @(posedge clk); #1;
        rst = 1; if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD; #2;
        vectors++;
        if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            miscompares++; $display("FAIL rmid_stale: got if_rv=%0b ls_rv=%0b data=%h want 0 0 0", if_rvalid, ls_rvalid, if_rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 0; if_req = 1; if_addr = 32'h48; mem_ready = 1; #2;
        vectors++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h48) begin
            miscompares++; $display("FAIL rmid_regrant: got gnt=%0b addr=%h want 1 48", if_gnt, mem_addr);
        end
        @(posedge clk); #1;
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77; #2;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h77) begin
            miscompares++; $display("FAIL rmid_rsp: got rv=%0b data=%h want 1 77", if_rvalid, if_rdata);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        if_req = 1; if_addr = 32'h80; mem_ready = 1;
        @(posedge clk); #1;
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 0; if_req = 1; mem_ready = 1; #2;
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++; $display("FAIL tmo_gnt: got %0b want 1", if_gnt);
        end
        @(posedge clk); #1;
        if_req = 0; mem_ready = 0; mem_rdata = 32'h1111_1111;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TO_CYC; k++) begin
            #2;
            vectors++;
            if (if_rvalid !== 1'b0 || timeout_err !== 1'b0) begin
                miscompares++; $display("FAIL tmo_early k=%0d: got rv=%0b err=%0b want 0 0", k, if_rvalid, timeout_err);
            end
            @(posedge clk); #1;
        end
        #2;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0) begin
            miscompares++; $display("FAIL tmo_fire: got rv=%0b data=%h want 1 0", if_rvalid, if_rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 1; mem_rdata = 32'h5555_5555; #2;
        vectors++;
        if (if_rvalid !== 1'b0 || timeout_err !== 1'b1 || if_rdata !== 32'h0) begin
            miscompares++; $display("FAIL tmo_late: got rv=%0b err=%0b data=%h want 0 1 0", if_rvalid, timeout_err, if_rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 0; #2;
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL tmo_sticky: got %0b want 1", timeout_err);
        end
`else
        for (int k = 1; k <= 3 * TO_CYC; k++) begin
            #2;
            vectors++;
            if (if_rvalid !== 1'b0 || timeout_err !== 1'b0) begin
                miscompares++; $display("FAIL nowd_wait k=%0d: got rv=%0b err=%0b want 0 0", k, if_rvalid, timeout_err);
            end
            @(posedge clk); #1;
        end
        mem_rvalid = 1; mem_rdata = 32'h2468_ACE0; #2;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h2468_ACE0 || timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL nowd_rsp: got rv=%0b data=%h err=%0b want 1 2468ace0 0", if_rvalid, if_rdata, timeout_err);
        end
`endif
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Transaction-level reference: one job in flight, fixed LS priority, IF forced
    // after LIMIT consecutive LS wins that it sat through.
    task automatic test_random();
        int          busy;      // 0 free, 1 issued but not accepted, 2 awaiting response
        bit          own_ls;
        int          streak;
        int          rsp_wait;
        logic [31:0] hold_if, hold_ls;
        bit          e_req, e_gnt, e_rsp, w_ls, drop_if, drop_ls;
        apply_reset();
        busy = 0; own_ls = 0; streak = 0; rsp_wait = -1; hold_if = 0; hold_ls = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & ~32'd3;
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1; ls_we = 1'($urandom); ls_addr = $urandom;
                ls_wdata = $urandom; ls_wmask = 4'($urandom);
            end
            mem_ready  = 1'($urandom);
            mem_rdata  = $urandom;
            mem_rvalid = (rsp_wait == 0);
            #2;
            e_req = 0; w_ls = own_ls;
            if (busy == 0 && (if_req || ls_req)) begin
                e_req = 1;
                w_ls  = ls_req && !(if_req && streak == LIMIT);
            end else if (busy == 1) begin
                e_req = 1;
            end
            e_gnt = e_req && mem_ready;
            e_rsp = (busy == 2) && mem_rvalid;
            if (e_rsp) begin
                if (own_ls) hold_ls = mem_rdata; else hold_if = mem_rdata;
            end
            vectors++;
            if (mem_req !== e_req) begin
                miscompares++; $display("FAIL rnd_req c=%0d: got %0b want %0b", c, mem_req, e_req);
            end
            vectors++;
            if (if_gnt !== (e_gnt && !w_ls) || ls_gnt !== (e_gnt && w_ls)) begin
                miscompares++; $display("FAIL rnd_gnt c=%0d: got if=%0b ls=%0b want if=%0b ls=%0b",
                                        c, if_gnt, ls_gnt, e_gnt && !w_ls, e_gnt && w_ls);
            end
            vectors++;
            if (if_rvalid !== (e_rsp && !own_ls) || ls_rvalid !== (e_rsp && own_ls)) begin
                miscompares++; $display("FAIL rnd_rvalid c=%0d: got if=%0b ls=%0b want if=%0b ls=%0b",
                                        c, if_rvalid, ls_rvalid, e_rsp && !own_ls, e_rsp && own_ls);
            end
            vectors++;
            if (if_rdata !== hold_if || ls_rdata !== hold_ls) begin
                miscompares++; $display("FAIL rnd_rdata c=%0d: got if=%h ls=%h want if=%h ls=%h",
                                        c, if_rdata, ls_rdata, hold_if, hold_ls);
            end
            if (e_req) begin
                vectors++;
                if (mem_addr !== (w_ls ? ls_addr : if_addr) || mem_we !== (w_ls && ls_we)
                    || mem_wmask !== (w_ls ? ls_wmask : 4'b0) || (w_ls && mem_wdata !== ls_wdata)) begin
                    miscompares++; $display("FAIL rnd_fields c=%0d: got addr=%h we=%0b m=%b wd=%h owner_ls=%0b",
                                            c, mem_addr, mem_we, mem_wmask, mem_wdata, w_ls);
                end
            end
            if (rsp_wait == 0) rsp_wait = -1; else if (rsp_wait > 0) rsp_wait--;
            if (e_rsp) busy = 0;
            if (busy == 0 && e_req) begin
                own_ls = w_ls;
                busy   = e_gnt ? 2 : 1;
            end else if (busy == 1 && e_gnt) begin
                busy = 2;
            end
            drop_if = 0; drop_ls = 0;
            if (e_gnt) begin
                rsp_wait = $urandom_range(0, 2);
                if (!w_ls) streak = 0;
                else if (if_req && streak < LIMIT) streak++;
                if (w_ls) drop_ls = 1; else drop_if = 1;
            end
            @(posedge clk); #1;
            if (drop_if) if_req = 0;
            if (drop_ls) ls_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_if_fetch();
        test_starvation();
        test_store_wait_acc();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
